// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, constants and init-engine state encodings for the MIPS register file
package regfile_pkg;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam logic [RF_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [RF_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;
    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read path with reset/enable/zero-reg/init masking and write-through bypass
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              rst,
    input  logic              init,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] rdata
);
    always_comb begin
        rdata = (!rst || re != READ_ENABLE || raddr == NOP_REG_ADDR || init) ? DATA_W'(ZERO_WORD) :
                (we == WRITE_ENABLE && waddr == raddr) ? wdata : word;
    end
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 GPR file, two combinational read ports with bypass, reset-less array zeroed by an init engine
// Optional debug read port enabled by defining REGFILE_DBG_PORT_EN
module regfile
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy
`ifdef REGFILE_DBG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
`endif
);
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              init;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    assign init      = (state_q == RF_INIT);
    assign init_busy = busy_q;

    // During INIT the write port is owned by the zeroing engine; pipeline writes are dropped
    always_comb begin
        state_d = (init && cnt_q == ADDR_W'(NUM_REGS - 1)) ? RF_RUN : state_q;
        cnt_d   = init ? cnt_q + ADDR_W'(1) : cnt_q;
        busy_d  = (state_d == RF_INIT);
        wr_en   = init || (we && waddr != NOP_REG_ADDR);
        wr_addr = init ? cnt_q : waddr;
        wr_data = init ? DATA_W'(ZERO_WORD) : wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RF_INIT;
            cnt_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    regfile_rd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd1 (
        .rst(rst), .init(init), .re(re1), .raddr(raddr1),
        .we(we), .waddr(waddr), .wdata(wdata), .word(mem_q[raddr1]), .rdata(rdata1)
    );

    regfile_rd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd2 (
        .rst(rst), .init(init), .re(re2), .raddr(raddr2),
        .we(we), .waddr(waddr), .wdata(wdata), .word(mem_q[raddr2]), .rdata(rdata2)
    );

`ifdef REGFILE_DBG_PORT_EN
    regfile_rd_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_dbg (
        .rst(rst), .init(init), .re(1'b1), .raddr(dbg_raddr),
        .we(1'b0), .waddr('0), .wdata('0), .word(mem_q[dbg_raddr]), .rdata(dbg_rdata)
    );
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed table-driven bench for regfile plus init/reset sequences
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        init_busy;
`ifdef REGFILE_DBG_PORT_EN
    logic [4:0]  dbg_raddr = '0;
    logic [31:0] dbg_rdata;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .init_busy(init_busy)
`ifdef REGFILE_DBG_PORT_EN
        , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`endif
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one INIT pass from reset release; returns cycles until init_busy drops
    task automatic run_init(output int n, input logic [4:0] probe);
        n = 0;
        while (init_busy && n < 100) begin
            we = (n == 9);
            waddr = 5'd3;
            wdata = 32'h55;
            re1 = 1'b1;
            raddr1 = probe;
            #1;
            chk("init_rd", rdata1, 32'h0);
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        we = 1'b0;
        re1 = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 5'd5,  32'h1234ABCD, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'h1234ABCD, 32'h1234ABCD};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd5,  32'h0,        32'h1234ABCD};
        vecs[3]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b1, 5'd7,  1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd5,  32'hDEADBEEF, 32'h1234ABCD};
        vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd31, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd30, 1'b1, 5'd31, 32'h0,        32'hCAFEF00D};
        vecs[8]  = '{1'b1, 5'd5,  32'h11111111, 1'b1, 5'd5,  1'b1, 5'd5,  32'h11111111, 32'h11111111};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd31, 32'h11111111, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 5'd12, 32'h77777777, 1'b0, 5'd12, 1'b1, 5'd3,  32'h0,        32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 1'b1, 5'd7,  32'h77777777, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd8,  1'b1, 5'd9,  32'h0,        32'hA5A5A5A5};

        re1 = 1'b1;
        raddr1 = 5'd1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, init_busy}, 32'h1);
        chk("rst_rd", rdata1, 32'h0);
        rst = 1'b1;
        run_init(n, 5'd3);
        chk("init_cycles", n, 31);
        chk("run_busy", {31'h0, init_busy}, 32'h0);

        for (int a = 1; a < 32; a++) begin
            re1 = 1'b1;
            raddr1 = 5'(a);
            re2 = 1'b1;
            raddr2 = 5'(32 - a);
            #1;
            chk("zero_rd1", rdata1, 32'h0);
            chk("zero_rd2", rdata2, 32'h0);
            @(negedge clk);
        end

        for (int i = 0; i < 13; i++) begin
            we = vecs[i].we;
            waddr = vecs[i].wa;
            wdata = vecs[i].wd;
            re1 = vecs[i].re1;
            raddr1 = vecs[i].ra1;
            re2 = vecs[i].re2;
            raddr2 = vecs[i].ra2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rdata1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rdata2, vecs[i].e2);
            @(negedge clk);
        end
        we = 1'b0;
        chk("busy_after_vecs", {31'h0, init_busy}, 32'h0);

        re2 = 1'b1;
        raddr2 = 5'd9;
        #1;
        chk("reg9_before_rst", rdata2, 32'hA5A5A5A5);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, init_busy}, 32'h1);
        chk("midrst_rd", rdata2, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run_init(n, 5'd9);
        chk("reinit_cycles", n, 31);
        re1 = 1'b1;
        raddr1 = 5'd9;
        re2 = 1'b1;
        raddr2 = 5'd5;
        #1;
        chk("reg9_after_init", rdata1, 32'h0);
        chk("reg5_after_init", rdata2, 32'h0);
        chk("busy_end", {31'h0, init_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
